// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
// Occupancy is carried as a 2-bit count of held entries.
package pipe_stage_reg_pkg;

  localparam int OCC_W = 2;

  typedef logic [OCC_W-1:0] occ_t;

  function automatic occ_t occ_of(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall and perf counters.
// Holds at all-ones instead of wrapping.
module pipe_stage_reg_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_r;

  // Count enabled cycles, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (en && (cnt_r != MAX_VAL)) begin
      cnt_r <= cnt_r + ONE_VAL;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with optional two-entry skid buffer,
// flush, sticky halt capture and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic             halted,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             main_valid_r, skid_valid_r, main_halt_r, skid_halt_r;
  logic [WIDTH-1:0] main_data_r, skid_data_r;
  logic             in_ready_r, halted_r, halt_pend_r;
  occ_t             occ_r;

  logic             main_valid_s, skid_valid_s, main_halt_s, skid_halt_s;
  logic [WIDTH-1:0] main_data_s, skid_data_s;
  logic             in_ready_s, in_ready_next_s, halted_s, halt_pend_s;
  logic             pop_s, accept_s, to_main_s, to_skid_s, move_s, stall_en_s;

  // Handshake decode; once a halt beat is inside the stage nothing more is taken in,
  // so beats behind a halt never reach the output.
  always_comb begin
    pop_s = main_valid_r && out_ready;
    if (SKID != 0) begin
      in_ready_s = in_ready_r;
    end else begin
      in_ready_s = (!main_valid_r || out_ready) && !halt_pend_r && !halted_r;
    end
    accept_s   = in_valid && in_ready_s && !flush;
    to_main_s  = accept_s && (!main_valid_r || (pop_s && !skid_valid_r));
    to_skid_s  = accept_s && !to_main_s;
    move_s     = pop_s && skid_valid_r && !flush;
    stall_en_s = main_valid_r && !out_ready;
  end

  // Next-state for both entries; payload is frozen on flush so out_data keeps its value.
  always_comb begin
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (to_main_s) begin
      main_valid_s = 1'b1;
      skid_valid_s = 1'b0;
    end else if (to_skid_s) begin
      main_valid_s = 1'b1;
      skid_valid_s = 1'b1;
    end else if (pop_s) begin
      main_valid_s = skid_valid_r;
      skid_valid_s = 1'b0;
    end else begin
      main_valid_s = main_valid_r;
      skid_valid_s = skid_valid_r;
    end

    main_data_s = move_s ? skid_data_r : (to_main_s ? in_data : main_data_r);
    main_halt_s = main_valid_s && (move_s ? skid_halt_r : (to_main_s ? in_halt : main_halt_r));
    skid_data_s = to_skid_s ? in_data : skid_data_r;
    skid_halt_s = to_skid_s ? in_halt : skid_halt_r;

    halted_s        = halted_r || (pop_s && main_halt_r);
    halt_pend_s     = !flush && (halt_pend_r || (accept_s && in_halt));
    in_ready_next_s = !skid_valid_s && !halt_pend_s && !halted_s;
  end

  // State registers; RST overrides every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_halt_r  <= 1'b0;
      skid_halt_r  <= 1'b0;
      main_data_r  <= {WIDTH{1'b0}};
      skid_data_r  <= {WIDTH{1'b0}};
      in_ready_r   <= 1'b1;
      halted_r     <= 1'b0;
      halt_pend_r  <= 1'b0;
      occ_r        <= 2'd0;
    end else begin
      main_valid_r <= main_valid_s;
      skid_valid_r <= skid_valid_s;
      main_halt_r  <= main_halt_s;
      skid_halt_r  <= skid_halt_s;
      main_data_r  <= main_data_s;
      skid_data_r  <= skid_data_s;
      in_ready_r   <= in_ready_next_s;
      halted_r     <= halted_s;
      halt_pend_r  <= halt_pend_s;
      occ_r        <= occ_of(main_valid_s, skid_valid_s);
    end
  end

  pipe_stage_reg_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .en  (stall_en_s),
    .clr (RST),
    .q   (stall_cnt)
  );

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign out_halt  = main_halt_r;
  assign halted    = halted_r;
  assign occ       = occ_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance and a SKID=0/CNT_W=4 instance share stimulus;
// per-instance scoreboards check ordering, a vector table checks cycle-level outputs.
module tb_pipe_stage_reg;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_halt, flush, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid, a_out_halt, a_halted;
  logic [7:0] a_out_data;
  logic [1:0] a_occ;
  logic [15:0] a_stall;

  logic       b_in_ready, b_out_valid, b_out_halt, b_halted;
  logic [7:0] b_out_data;
  logic [1:0] b_occ;
  logic [3:0] b_stall;

  int total = 0;
  int bad = 0;
  int pops_03 = 0;
  int pops_55 = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  typedef struct {
    logic       r;
    logic       iv;
    logic [7:0] d;
    logic       fl;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic       eir;
    logic [1:0] eocc;
    logic [15:0] est;
    logic       cb;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(8), .SKID(1), .CNT_W(16)) dut_a (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_halt(in_halt), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_halt(a_out_halt), .halted(a_halted), .occ(a_occ),
    .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.WIDTH(8), .SKID(0), .CNT_W(4)) dut_b (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_halt(in_halt), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_halt(b_out_halt), .halted(b_halted), .occ(b_occ),
    .stall_cnt(b_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic h, input logic fl,
                       input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_halt   = h;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic iv, logic [7:0] d, logic fl, logic ordy, logic ev,
                              logic [7:0] ed, logic eir, logic [1:0] eocc, logic [15:0] est,
                              logic cb);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy; v.ev = ev; v.ed = ed;
    v.eir = eir; v.eocc = eocc; v.est = est; v.cb = cb;
    return v;
  endfunction

  // Scoreboards: handshakes are evaluated mid-cycle, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (a_out_valid && out_ready) begin
        if (a_out_data == 8'h03) pops_03++;
        if (a_out_data == 8'h55) pops_55++;
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_sb_unexpected: got 0x%0h want none", a_out_data);
        end else begin
          chk("a_sb", 32'(a_out_data), 32'(q_a.pop_front()));
        end
      end
      if (flush) q_a.delete();
      else if (in_valid && a_in_ready) q_a.push_back(in_data);

      if (b_out_valid && out_ready) begin
        if (b_out_data == 8'h03) pops_03++;
        if (b_out_data == 8'h55) pops_55++;
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_sb_unexpected: got 0x%0h want none", b_out_data);
        end else begin
          chk("b_sb", 32'(b_out_data), 32'(q_b.pop_front()));
        end
      end
      if (flush) q_b.delete();
      else if (in_valid && b_in_ready) q_b.push_back(in_data);
    end
  end

  initial begin
    // Streaming: one beat per cycle, both instances, output one cycle after accept.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(i == 0, 1'b1, 8'h11 + 8'(i), 1'b0, 1'b1, 1'b1, 8'h11 + 8'(i), 1'b1,
                       2'd1, 16'd0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd0, 1'b1));
    // Backpressure into the skid entry, then release.
    tbl.push_back(mk(1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b1, 2'd1, 16'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0B, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 2'd2, 16'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 2'd2, 16'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b1, 8'h0A, 1'b0, 2'd2, 16'd3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h0B, 1'b1, 2'd1, 16'd3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b1, 2'd1, 16'd3, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd3, 1'b0));
    // Flush from full, recovery, then flush coinciding with a pop.
    tbl.push_back(mk(1'b1, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 2'd1, 16'd0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 2'd2, 16'd1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 16'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h23, 1'b0, 1'b1, 1'b1, 8'h23, 1'b1, 2'd1, 16'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 8'h31, 1'b1, 2'd1, 16'd2, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h32, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0, 16'd2, 1'b0));

    do_reset();
    step();
    chk("rst_a_ov", 32'(a_out_valid), 32'd0);
    chk("rst_a_od", 32'(a_out_data), 32'd0);
    chk("rst_a_oh", 32'(a_out_halt), 32'd0);
    chk("rst_a_occ", 32'(a_occ), 32'd0);
    chk("rst_a_ir", 32'(a_in_ready), 32'd1);
    chk("rst_a_halted", 32'(a_halted), 32'd0);
    chk("rst_a_stall", 32'(a_stall), 32'd0);
    chk("rst_b_ov", 32'(b_out_valid), 32'd0);
    chk("rst_b_ir", 32'(b_in_ready), 32'd1);
    chk("rst_b_stall", 32'(b_stall), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].r) do_reset();
      drive(tbl[i].iv, tbl[i].d, 1'b0, tbl[i].fl, tbl[i].ordy);
      step();
      chk($sformatf("v%0d_a_ov", i), 32'(a_out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("v%0d_a_od", i), 32'(a_out_data), 32'(tbl[i].ed));
      chk($sformatf("v%0d_a_ir", i), 32'(a_in_ready), 32'(tbl[i].eir));
      chk($sformatf("v%0d_a_occ", i), 32'(a_occ), 32'(tbl[i].eocc));
      chk($sformatf("v%0d_a_stall", i), 32'(a_stall), 32'(tbl[i].est));
      if (tbl[i].cb) begin
        chk($sformatf("v%0d_b_ov", i), 32'(b_out_valid), 32'(tbl[i].ev));
        if (tbl[i].ev) chk($sformatf("v%0d_b_od", i), 32'(b_out_data), 32'(tbl[i].ed));
      end
    end
    chk("no_55_out", 32'(pops_55), 32'd0);

    // Halt beat followed back-to-back by another beat that must never come out.
    do_reset();
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    step();
    chk("h_od1", 32'(a_out_data), 32'h01);
    chk("h_halted0", 32'(a_halted), 32'd0);
    drive(1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    step();
    chk("h_od2", 32'(a_out_data), 32'h02);
    chk("h_oh2", 32'(a_out_halt), 32'd1);
    chk("h_halted_pre", 32'(a_halted), 32'd0);
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
    step();
    chk("h_a_halted", 32'(a_halted), 32'd1);
    chk("h_b_halted", 32'(b_halted), 32'd1);
    chk("h_a_ir", 32'(a_in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("h_hold%0d_ir", k), 32'(a_in_ready), 32'd0);
      chk($sformatf("h_hold%0d_ov", k), 32'(a_out_valid), 32'd0);
    end
    chk("h_no_03", 32'(pops_03), 32'd0);
    do_reset();
    chk("h_rst_halted", 32'(a_halted), 32'd0);
    chk("h_rst_ir", 32'(a_in_ready), 32'd1);

    // Halt beat stuck behind a stall: halted only after it finally pops.
    drive(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("hs_ov", 32'(a_out_valid), 32'd1);
    chk("hs_oh", 32'(a_out_halt), 32'd1);
    chk("hs_halted0", 32'(a_halted), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    chk("hs_halted1", 32'(a_halted), 32'd1);
    chk("hs_ov0", 32'(a_out_valid), 32'd0);

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    chk("sat_b_15", 32'(b_stall), 32'd15);
    chk("sat_a_20", 32'(a_stall), 32'd20);
    repeat (5) step();
    chk("sat_b_hold", 32'(b_stall), 32'd15);
    chk("sat_a_25", 32'(a_stall), 32'd25);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step();
    chk("sat_drain_ov", 32'(a_out_valid), 32'd0);
    chk("sat_b_after", 32'(b_stall), 32'd15);
    step();
    chk("sb_a_empty", 32'(q_a.size()), 32'd0);
    chk("sb_b_empty", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
